// File: rtl/serial_subtractor_32.sv
// rtl/serial_subtractor_32.sv - digit-serial a - b mod 2^WIDTH with borrow-out and valid/ready handshakes
module serial_subtractor_32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_reg_q, borrow_reg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT:0]   t;

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        borrow_reg_d = borrow_reg_q;
        cnt_d        = cnt_q;
        // One extra bit catches the digit borrow as the sign of the partial difference
        t = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]} - (DIGIT+1)'(borrow_reg_q);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d       = a;
                    b_sh_d       = b;
                    borrow_reg_d = 1'b0;
                    cnt_d        = '0;
                    in_ready_d   = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                res_d        = (res_q >> DIGIT) | (WIDTH'(t[DIGIT-1:0]) << (WIDTH - DIGIT));
                borrow_reg_d = t[DIGIT];
                a_sh_d       = a_sh_q >> DIGIT;
                b_sh_d       = b_sh_q >> DIGIT;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d      = res_d;
                    borrow_d    = t[DIGIT];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            borrow_reg_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            borrow_reg_q <= borrow_reg_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_32.sv
// tb/tb_serial_subtractor_32.sv - scoreboard bench for serial_subtractor_32 at DIGIT 4, 1 and 32
module tb_serial_subtractor_32;
    logic        clk;
    logic        rst_v  [3];
    logic        iv     [3];
    logic        ir     [3];
    logic [31:0] av     [3];
    logic [31:0] bv     [3];
    logic        ov     [3];
    logic        ordy   [3];
    logic [31:0] dv     [3];
    logic        bw     [3];
    logic        rdy_rand [3];

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
        serial_subtractor_32 #(.WIDTH(32), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (av[g]),
            .b         (bv[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .diff      (dv[g]),
            .borrow    (bw[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sb_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int i, input logic [32:0] e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int i, output logic [32:0] e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic sb_drop_last(input int i);
        logic [32:0] e;
        case (i)
            0: e = q0.pop_back();
            1: e = q1.pop_back();
            default: e = q2.pop_back();
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic monitor(input int i);
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst_v[i] && ov[i] && ordy[i]) begin
                checks++;
                if (sb_size(i) == 0) begin
                    errors++;
                    $display("FAIL unexpected_out[%0d] got borrow=%0b diff=%h required no output", i, bw[i], dv[i]);
                end else begin
                    sb_pop(i, e);
                    if ({bw[i], dv[i]} !== e) begin
                        errors++;
                        $display("FAIL result[%0d] got borrow=%0b diff=%h required borrow=%0b diff=%h",
                                 i, bw[i], dv[i], e[32], e[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic rdy_proc(input int i);
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand[i]) ordy[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input int i, input logic [31:0] x, input logic [31:0] y, input logic [32:0] e);
        int   n;
        logic acc;
        av[i] = x;
        bv[i] = y;
        iv[i] = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 400) begin
            @(negedge clk);
            if (ir[i]) acc = 1'b1;
            else n++;
        end
        if (acc) begin
            sb_push(i, e);
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%0d] got in_ready=0 required in_ready=1", i);
        end
        iv[i] = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid is seen; returns at a negedge
    task automatic wait_valid(input int i, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ov[i] && n < 100);
    endtask

    task automatic run_random(input int i, input int count);
        logic [31:0] x, y, s;
        logic        c;
        logic [32:0] e;
        logic        rt;
        for (int t = 0; t < count; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            x  = $urandom;
            y  = $urandom;
            rt = 1'b0;
            case ($urandom_range(0, 7))
                0: y = x;
                1: x = 32'h0;
                2: y = 32'hFFFF_FFFF;
                3, 4: begin
                    // Round trip: subtracting b from (a + b) must give back a, borrowing iff the add wrapped
                    {c, s} = {1'b0, x} + {1'b0, y};
                    e  = {c, x};
                    x  = s;
                    rt = 1'b1;
                end
                default: ;
            endcase
            if (!rt) e = {(x < y), x - y};
            send(i, x, y, e);
        end
    endtask

    initial begin
        int          n;
        logic [32:0] cap;
        for (int i = 0; i < 3; i++) begin
            rst_v[i]    = 1'b1;
            iv[i]       = 1'b0;
            av[i]       = '0;
            bv[i]       = '0;
            ordy[i]     = 1'b1;
            rdy_rand[i] = 1'b0;
        end
        ordy[0] = 1'b0;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            rdy_proc(0);
            rdy_proc(1);
            rdy_proc(2);
        join_none

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state[%0d]", i), {60'd0, ir[i], ov[i], bw[i], (dv[i] == 32'h0)}, {60'd0, 4'b1001});
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        @(posedge clk);
        #1;

        // Basic with backpressure in DONE
        send(0, 32'h5, 32'h3, {1'b0, 32'h2});
        wait_valid(0, n);
        chk("latency_basic", 64'(n), 64'd8);
        cap = {bw[0], dv[0]};
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_in_done", {29'd0, ir[0], ov[0], bw[0], dv[0]}, {29'd0, 1'b0, 1'b1, cap});
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_hs", {62'd0, ir[0], ov[0]}, {62'd0, 2'b10});
        @(posedge clk);
        #1;

        send(0, 32'h0000_0000, 32'h0000_0001, {1'b1, 32'hFFFF_FFFF});
        send(0, 32'h8000_0000, 32'hFFFF_FFFF, {1'b1, 32'h8000_0001});
        send(0, 32'h1000_0000, 32'h0000_0001, {1'b0, 32'h0FFF_FFFF});
        send(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, {1'b0, 32'h0});
        wait_valid(0, n);
        chk("latency_b2b", 64'(n), 64'd8);
        chk("in_ready_at_hs", {63'd0, ir[0]}, 64'd0);
        @(negedge clk);
        chk("b2b_ready_rise", {62'd0, ir[0], ov[0]}, {62'd0, 2'b10});
        @(posedge clk);
        #1;

        // Reset during the third RUN cycle discards the transaction
        send(0, 32'h1234_5678, 32'h0000_0001, {1'b0, 32'h1234_5677});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        #1;
        chk("rst_mid_run", {29'd0, ir[0], ov[0], bw[0], dv[0]}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
        sb_drop_last(0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        @(posedge clk);
        #1;
        send(0, 32'h7, 32'h9, {1'b1, 32'hFFFF_FFFE});
        wait_valid(0, n);
        chk("latency_after_rst", 64'(n), 64'd8);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) rdy_rand[i] = 1'b1;
        fork
            run_random(0, 1500);
            run_random(1, 400);
            run_random(2, 1500);
        join

        n = 0;
        while ((sb_size(0) + sb_size(1) + sb_size(2)) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(sb_size(0) + sb_size(1) + sb_size(2)), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
